// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl
// Four-channel programmable tick scheduler. Each channel divides CLOCK by
// (m+1): it emits a one-cycle tick at the end of every period and toggles a
// square wave on each tick. A channel runs either continuously or for a burst
// of N ticks, after which it returns to idle. Divisor changes made while a
// channel runs are held in a shadow register and take effect only at the next
// period boundary, so a change never produces a runt tick. A single
// valid/ready port carries configuration requests.
//
// Ports
//   CLOCK      system clock, all logic on the rising edge
//   RESET      synchronous active-high reset
//   cfg_valid  configuration request valid
//   cfg_ready  request accepted when cfg_valid & cfg_ready (low while the
//              addressed channel still has a shadow divisor waiting)
//   cfg_ch     target channel 0..3
//   cfg_op     00 SET_DIV, 01 ENABLE, 10 DISABLE, 11 BURST
//   cfg_data   divisor (SET_DIV) or burst count in the low BURST_W bits
//   tick       per-channel one-cycle pulse at the end of each period
//   clk_out    per-channel square wave, toggles on each tick
//   active     per-channel running flag
//   pending    per-channel shadow divisor waiting for a period boundary
module tick_sched_ctrl #(
    parameter int unsigned CW        = 32,
    parameter int unsigned DEFAULT_M = 2499,
    parameter int unsigned BURST_W   = 16
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_ch,
    input  logic [1:0]    cfg_op,
    input  logic [CW-1:0] cfg_data,
    output logic [3:0]    tick,
    output logic [3:0]    clk_out,
    output logic [3:0]    active,
    output logic [3:0]    pending
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic [1:0]         OP_SET_DIV = 2'b00;
    localparam logic [1:0]         OP_ENABLE  = 2'b01;
    localparam logic [1:0]         OP_DISABLE = 2'b10;
    localparam logic [1:0]         OP_BURST   = 2'b11;
    localparam logic [CW-1:0]      M_RESET    = CW'(DEFAULT_M);
    localparam logic [CW-1:0]      CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

    ch_state_e          state_r    [4];
    ch_state_e          state_n_s  [4];
    logic [CW-1:0]      count_r    [4];
    logic [CW-1:0]      count_n_s  [4];
    logic [CW-1:0]      m_r        [4];
    logic [CW-1:0]      m_n_s      [4];
    logic [CW-1:0]      shadow_r   [4];
    logic [CW-1:0]      shadow_n_s [4];
    logic [BURST_W-1:0] burst_r    [4];
    logic [BURST_W-1:0] burst_n_s  [4];
    logic [3:0]         tick_r;
    logic [3:0]         tick_n_s;
    logic [3:0]         clk_r;
    logic [3:0]         clk_n_s;
    logic [3:0]         pending_r;
    logic [3:0]         pending_n_s;
    logic [3:0]         hit_s;
    logic               accept_s;
    logic [BURST_W-1:0] burst_len_s;

    assign cfg_ready   = ~pending_r[cfg_ch];
    assign accept_s    = cfg_valid & cfg_ready;
    assign burst_len_s = cfg_data[BURST_W-1:0];
    assign tick        = tick_r;
    assign clk_out     = clk_r;
    assign pending     = pending_r;

    // Active flag is simply the RUN state of each channel register.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            active[c] = (state_r[c] == ST_RUN);
        end
    end

    // Next-state logic: period counting first, then an accepted config op
    // overrides count/active (a DISABLE also cancels that cycle's tick).
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            state_n_s[c]   = state_r[c];
            count_n_s[c]   = count_r[c];
            m_n_s[c]       = m_r[c];
            shadow_n_s[c]  = shadow_r[c];
            burst_n_s[c]   = burst_r[c];
            tick_n_s[c]    = 1'b0;
            clk_n_s[c]     = clk_r[c];
            pending_n_s[c] = pending_r[c];
            hit_s[c]       = accept_s && (cfg_ch == 2'(c));

            if (state_r[c] == ST_RUN) begin
                if (count_r[c] == m_r[c]) begin
                    count_n_s[c] = CNT_ZERO;
                    tick_n_s[c]  = 1'b1;
                    clk_n_s[c]   = ~clk_r[c];
                    // A waiting shadow divisor governs the period that starts now.
                    if (pending_r[c]) begin
                        m_n_s[c]       = shadow_r[c];
                        pending_n_s[c] = 1'b0;
                    end else begin
                        m_n_s[c]       = m_r[c];
                    end
                    // Last burst tick: drop active together with the tick.
                    if (burst_r[c] == BURST_ONE) begin
                        state_n_s[c] = ST_IDLE;
                        clk_n_s[c]   = 1'b0;
                        burst_n_s[c] = BURST_ZERO;
                    end else if (burst_r[c] != BURST_ZERO) begin
                        burst_n_s[c] = burst_r[c] - BURST_ONE;
                    end else begin
                        burst_n_s[c] = BURST_ZERO;
                    end
                end else begin
                    count_n_s[c] = count_r[c] + CNT_ONE;
                end
            end else begin
                count_n_s[c] = CNT_ZERO;
                clk_n_s[c]   = 1'b0;
            end

            case ({hit_s[c], cfg_op})
                {1'b1, OP_SET_DIV}: begin
                    // A channel that stays running must wait for its boundary;
                    // one that is (or just became) idle takes the value now.
                    if (state_n_s[c] == ST_RUN) begin
                        shadow_n_s[c]  = cfg_data;
                        pending_n_s[c] = 1'b1;
                    end else begin
                        m_n_s[c]       = cfg_data;
                    end
                end
                {1'b1, OP_ENABLE}: begin
                    state_n_s[c] = ST_RUN;
                    count_n_s[c] = CNT_ZERO;
                    burst_n_s[c] = BURST_ZERO;
                end
                {1'b1, OP_DISABLE}: begin
                    state_n_s[c]   = ST_IDLE;
                    count_n_s[c]   = CNT_ZERO;
                    clk_n_s[c]     = 1'b0;
                    tick_n_s[c]    = 1'b0;
                    burst_n_s[c]   = BURST_ZERO;
                    m_n_s[c]       = pending_r[c] ? shadow_r[c] : m_n_s[c];
                    pending_n_s[c] = 1'b0;
                end
                {1'b1, OP_BURST}: begin
                    // A zero-length burst is treated exactly like DISABLE.
                    if (burst_len_s == BURST_ZERO) begin
                        state_n_s[c]   = ST_IDLE;
                        count_n_s[c]   = CNT_ZERO;
                        clk_n_s[c]     = 1'b0;
                        tick_n_s[c]    = 1'b0;
                        burst_n_s[c]   = BURST_ZERO;
                        m_n_s[c]       = pending_r[c] ? shadow_r[c] : m_n_s[c];
                        pending_n_s[c] = 1'b0;
                    end else begin
                        state_n_s[c] = ST_RUN;
                        count_n_s[c] = CNT_ZERO;
                        burst_n_s[c] = burst_len_s;
                    end
                end
                default: begin
                    // No request for this channel: keep the counting result.
                    state_n_s[c] = state_n_s[c];
                end
            endcase
        end
    end

    // Channel state and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tick_r    <= 4'b0000;
            clk_r     <= 4'b0000;
            pending_r <= 4'b0000;
            for (int c = 0; c < 4; c++) begin
                state_r[c]  <= ST_IDLE;
                count_r[c]  <= CNT_ZERO;
                m_r[c]      <= M_RESET;
                shadow_r[c] <= CNT_ZERO;
                burst_r[c]  <= BURST_ZERO;
            end
        end else begin
            tick_r    <= tick_n_s;
            clk_r     <= clk_n_s;
            pending_r <= pending_n_s;
            for (int c = 0; c < 4; c++) begin
                state_r[c]  <= state_n_s[c];
                count_r[c]  <= count_n_s[c];
                m_r[c]      <= m_n_s[c];
                shadow_r[c] <= shadow_n_s[c];
                burst_r[c]  <= burst_n_s[c];
            end
        end
    end

endmodule
